// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_pkg;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StFlush = 2'd1
  } pipe_state_e;

  localparam logic [1:0] PCSEL_SEQ = 2'd0;
  localparam logic [1:0] PCSEL_EXC = 2'd1;
  localparam logic [1:0] PCSEL_EPC = 2'd2;

  localparam int unsigned DEFAULT_MULT_CYCLES = 5;
  localparam int unsigned DEFAULT_DIV_CYCLES  = 10;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard inputs and pipe-register control outputs of pipe_ctrl.
// PIPE_CTRL_PERF_EN adds the stall/flush performance counters.
interface pipe_ctrl_if;
  logic        stall_req_d;
  logic        md_start_e;
  logic        md_is_div_e;
  logic        md_use_d;
  logic        exc_m;
  logic        eret_m;
  logic        pc_en;
  logic        d_en;
  logic        clr_d;
  logic        clr_e;
  logic        clr_m;
  logic        clr_w;
  logic [1:0]  pc_sel;
  logic        md_busy;
  logic        md_go;
  logic [1:0]  state;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  modport master (
    input  stall_req_d, md_start_e, md_is_div_e, md_use_d, exc_m, eret_m,
    output pc_en, d_en, clr_d, clr_e, clr_m, clr_w, pc_sel, md_busy, md_go, state
`ifdef PIPE_CTRL_PERF_EN
    , output stall_cnt, flush_cnt
`endif
  );

  modport slave (
    output stall_req_d, md_start_e, md_is_div_e, md_use_d, exc_m, eret_m,
    input  pc_en, d_en, clr_d, clr_e, clr_m, clr_w, pc_sel, md_busy, md_go, state
`ifdef PIPE_CTRL_PERF_EN
    , input stall_cnt, flush_cnt
`endif
  );
endinterface

// File: rtl/pipe_ctrl_md_seq.sv
// Mult/div busy sequencer: qualifies the start and counts down the busy window.
module md_seq #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start_i,
  input  logic is_div_i,
  input  logic exc_i,
  input  logic eret_i,
  input  logic run_i,
  output logic go_o,
  output logic busy_o
);

  localparam int unsigned CntW = $clog2(DIV_CYCLES + 1);

  logic [CntW-1:0] cnt_d, cnt_q;

  // A start that coincides with a redirect belongs to a squashed instruction.
  assign go_o   = start_i & ~exc_i & ~eret_i & run_i & reset_n;
  assign busy_o = (cnt_q != '0);

  always_comb begin
    cnt_d = cnt_q;
    if (go_o) begin
      cnt_d = is_div_i ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush controller for the five-stage pipeline; owns the md busy sequencer.
// Optional PIPE_CTRL_PERF_EN adds stall_cnt/flush_cnt counters.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = DEFAULT_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = DEFAULT_DIV_CYCLES
) (
  input logic         clk,
  input logic         reset_n,
  pipe_ctrl_if.master bus
);

  pipe_state_e state_d, state_q;
  logic        md_go, md_busy, stall;
  logic        pc_en, d_en, clr_d, clr_e, clr_m, clr_w;
  logic [1:0]  pc_sel;
  logic        stall_cyc, flush_ent;

  md_seq #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_seq (
    .clk      (clk),
    .reset_n  (reset_n),
    .start_i  (bus.md_start_e),
    .is_div_i (bus.md_is_div_e),
    .exc_i    (bus.exc_m),
    .eret_i   (bus.eret_m),
    .run_i    (state_q == StRun),
    .go_o     (md_go),
    .busy_o   (md_busy)
  );

  assign stall = bus.stall_req_d | (bus.md_use_d & (md_busy | md_go));

  always_comb begin
    state_d   = state_q;
    pc_en     = 1'b1;
    d_en      = 1'b1;
    clr_d     = 1'b0;
    clr_e     = 1'b0;
    clr_m     = 1'b0;
    clr_w     = 1'b0;
    pc_sel    = PCSEL_SEQ;
    stall_cyc = 1'b0;
    flush_ent = 1'b0;
    if (!reset_n) begin
      pc_en   = 1'b0;
      d_en    = 1'b0;
      clr_d   = 1'b1;
      clr_e   = 1'b1;
      clr_m   = 1'b1;
      clr_w   = 1'b1;
      state_d = StRun;
    end else begin
      unique case (state_q)
        StRun: begin
          if (bus.exc_m || bus.eret_m) begin
            clr_d     = 1'b1;
            clr_e     = 1'b1;
            clr_m     = 1'b1;
            pc_sel    = bus.exc_m ? PCSEL_EXC : PCSEL_EPC;
            flush_ent = 1'b1;
            state_d   = StFlush;
          end else if (stall) begin
            pc_en     = 1'b0;
            d_en      = 1'b0;
            clr_e     = 1'b1;
            stall_cyc = 1'b1;
          end
        end
        StFlush: begin
          // Handler fetch is in flight; drop whatever D picked up meanwhile.
          clr_d   = 1'b1;
          state_d = StRun;
        end
        default: state_d = StRun;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  assign bus.pc_en   = pc_en;
  assign bus.d_en    = d_en;
  assign bus.clr_d   = clr_d;
  assign bus.clr_e   = clr_e;
  assign bus.clr_m   = clr_m;
  assign bus.clr_w   = clr_w;
  assign bus.pc_sel  = pc_sel;
  assign bus.md_busy = md_busy;
  assign bus.md_go   = md_go;
  assign bus.state   = state_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt_d, stall_cnt_q, flush_cnt_d, flush_cnt_q;

  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'd0, stall_cyc};
    flush_cnt_d = flush_cnt_q + {31'd0, flush_ent};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
`else
  logic unused_perf;
  assign unused_perf = stall_cyc ^ flush_ent;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed scoreboard bench for pipe_ctrl: driver queues per-cycle expectations,
// a negedge monitor pops and compares them.
module tb_pipe_ctrl;

  typedef struct packed {
    logic       rst_n;
    logic       stall;
    logic       start;
    logic       is_div;
    logic       use_md;
    logic       exc;
    logic       eret;
  } in_t;

  typedef struct packed {
    logic       pc_en;
    logic       d_en;
    logic       d_en_chk;
    logic       clr_d;
    logic       clr_e;
    logic       clr_m;
    logic       clr_w;
    logic [1:0] pc_sel;
    logic       md_busy;
    logic       md_go;
    logic [1:0] state;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  exp_t  exp_q[$];
  string name_q[$];

  pipe_ctrl_if bus();

  pipe_ctrl #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic in_t inp(logic r, logic s, logic st, logic dv, logic u, logic x, logic e);
    in_t i;
    i = '{rst_n: r, stall: s, start: st, is_div: dv, use_md: u, exc: x, eret: e};
    return i;
  endfunction

  function automatic exp_t e_reset();
    return '{pc_en: 0, d_en: 0, d_en_chk: 1, clr_d: 1, clr_e: 1, clr_m: 1, clr_w: 1,
             pc_sel: 2'd0, md_busy: 0, md_go: 0, state: 2'd0};
  endfunction

  function automatic exp_t e_run(logic busy, logic go);
    return '{pc_en: 1, d_en: 1, d_en_chk: 1, clr_d: 0, clr_e: 0, clr_m: 0, clr_w: 0,
             pc_sel: 2'd0, md_busy: busy, md_go: go, state: 2'd0};
  endfunction

  function automatic exp_t e_stall(logic busy, logic go);
    return '{pc_en: 0, d_en: 0, d_en_chk: 1, clr_d: 0, clr_e: 1, clr_m: 0, clr_w: 0,
             pc_sel: 2'd0, md_busy: busy, md_go: go, state: 2'd0};
  endfunction

  function automatic exp_t e_exc(logic [1:0] sel, logic busy);
    return '{pc_en: 1, d_en: 0, d_en_chk: 0, clr_d: 1, clr_e: 1, clr_m: 1, clr_w: 0,
             pc_sel: sel, md_busy: busy, md_go: 0, state: 2'd0};
  endfunction

  function automatic exp_t e_flush(logic busy);
    return '{pc_en: 1, d_en: 0, d_en_chk: 0, clr_d: 1, clr_e: 0, clr_m: 0, clr_w: 0,
             pc_sel: 2'd0, md_busy: busy, md_go: 0, state: 2'd1};
  endfunction

  task automatic step(input string nm, input in_t i, input exp_t e);
    @(posedge clk);
    #1;
    reset_n         = i.rst_n;
    bus.stall_req_d = i.stall;
    bus.md_start_e  = i.start;
    bus.md_is_div_e = i.is_div;
    bus.md_use_d    = i.use_md;
    bus.exc_m       = i.exc;
    bus.eret_m      = i.eret;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: every cycle the DUT presents a full control vector.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      exp_t  a;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = '{pc_en: bus.pc_en, d_en: bus.d_en, d_en_chk: e.d_en_chk, clr_d: bus.clr_d,
             clr_e: bus.clr_e, clr_m: bus.clr_m, clr_w: bus.clr_w, pc_sel: bus.pc_sel,
             md_busy: bus.md_busy, md_go: bus.md_go, state: bus.state};
      if (!e.d_en_chk) a.d_en = e.d_en;
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s @%0t: got pc_en=%b d_en=%b clr=%b%b%b%b sel=%0d busy=%b go=%b st=%0d; want pc_en=%b d_en=%b clr=%b%b%b%b sel=%0d busy=%b go=%b st=%0d",
                 nm, $time, a.pc_en, a.d_en, a.clr_d, a.clr_e, a.clr_m, a.clr_w, a.pc_sel,
                 a.md_busy, a.md_go, a.state, e.pc_en, e.d_en, e.clr_d, e.clr_e, e.clr_m,
                 e.clr_w, e.pc_sel, e.md_busy, e.md_go, e.state);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.stall_req_d = 0;
    bus.md_start_e  = 0;
    bus.md_is_div_e = 0;
    bus.md_use_d    = 0;
    bus.exc_m       = 0;
    bus.eret_m      = 0;

    for (int k = 0; k < 3; k++) step("reset_hold", inp(0, 0, 0, 0, 0, 0, 0), e_reset());
    step("reset_release", inp(1, 0, 0, 0, 0, 0, 0), e_run(0, 0));
    step("run_idle", inp(1, 0, 0, 0, 0, 0, 0), e_run(0, 0));

    step("load_use", inp(1, 1, 0, 0, 0, 0, 0), e_stall(0, 0));
    step("load_use_after", inp(1, 0, 0, 0, 0, 0, 0), e_run(0, 0));

    step("div_start", inp(1, 0, 1, 1, 0, 0, 0), e_run(0, 1));
    for (int k = 0; k < 10; k++) step("div_stall", inp(1, 0, 0, 0, 1, 0, 0), e_stall(1, 0));
    step("div_release", inp(1, 0, 0, 0, 1, 0, 0), e_run(0, 0));
    step("div_idle", inp(1, 0, 0, 0, 0, 0, 0), e_run(0, 0));

    step("mult_start", inp(1, 0, 1, 0, 0, 0, 0), e_run(0, 1));
    for (int k = 0; k < 5; k++) step("mult_stall", inp(1, 0, 0, 0, 1, 0, 0), e_stall(1, 0));
    step("mult_release", inp(1, 0, 0, 0, 1, 0, 0), e_run(0, 0));
    step("mult_idle", inp(1, 0, 0, 0, 0, 0, 0), e_run(0, 0));

    step("exc_with_stall", inp(1, 1, 0, 0, 0, 1, 0), e_exc(2'd1, 0));
    step("flush_ignores_exc", inp(1, 1, 0, 0, 0, 1, 0), e_flush(0));
    step("after_flush", inp(1, 0, 0, 0, 0, 0, 0), e_run(0, 0));

    step("exc_with_md_start", inp(1, 0, 1, 1, 0, 1, 0), e_exc(2'd1, 0));
    step("flush_md_start", inp(1, 0, 1, 1, 0, 0, 0), e_flush(0));
    step("no_busy_after_exc", inp(1, 0, 0, 0, 0, 0, 0), e_run(0, 0));

    step("eret", inp(1, 0, 0, 0, 0, 0, 1), e_exc(2'd2, 0));
    step("eret_flush", inp(1, 0, 0, 0, 0, 0, 0), e_flush(0));
    step("exc_beats_eret", inp(1, 0, 0, 0, 0, 1, 1), e_exc(2'd1, 0));
    step("exc_eret_flush", inp(1, 0, 0, 0, 0, 0, 0), e_flush(0));
    step("run_again", inp(1, 0, 0, 0, 0, 0, 0), e_run(0, 0));

    step("midop_start", inp(1, 0, 1, 1, 0, 0, 0), e_run(0, 1));
    step("midop_busy", inp(1, 0, 0, 0, 0, 0, 0), e_run(1, 0));
    step("midop_busy", inp(1, 0, 0, 0, 0, 0, 0), e_run(1, 0));
    step("midop_reset", inp(0, 0, 0, 0, 0, 0, 0), e_reset());
    step("midop_release", inp(1, 0, 0, 0, 1, 0, 0), e_run(0, 0));

    for (int k = 0; k < 3; k++) begin
      step("perf_stall", inp(1, 1, 0, 0, 0, 0, 0), e_stall(0, 0));
      step("perf_gap", inp(1, 0, 0, 0, 0, 0, 0), e_run(0, 0));
    end
    for (int k = 0; k < 2; k++) begin
      step("perf_eret", inp(1, 0, 0, 0, 0, 0, 1), e_exc(2'd2, 0));
      step("perf_flush", inp(1, 0, 0, 0, 0, 0, 0), e_flush(0));
    end
    step("perf_settle", inp(1, 0, 0, 0, 0, 0, 0), e_run(0, 0));
`ifdef PIPE_CTRL_PERF_EN
    checks++;
    if (bus.stall_cnt !== 32'd3) begin
      errors++;
      $display("FAIL stall_cnt: got %0d want 3", bus.stall_cnt);
    end
    checks++;
    if (bus.flush_cnt !== 32'd2) begin
      errors++;
      $display("FAIL flush_cnt: got %0d want 2", bus.flush_cnt);
    end
`endif

    step("exc_md_start", inp(1, 0, 1, 0, 0, 0, 0), e_run(0, 1));
    step("exc_md_counting", inp(1, 0, 0, 0, 0, 1, 0), e_exc(2'd1, 1));
    step("exc_md_flush", inp(1, 0, 0, 0, 0, 0, 0), e_flush(1));
    for (int k = 0; k < 3; k++) step("exc_md_tail", inp(1, 0, 0, 0, 0, 0, 0), e_run(1, 0));
    step("exc_md_done", inp(1, 0, 0, 0, 0, 0, 0), e_run(0, 0));

    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
